// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 2-of-3 majority bit recovery,
// optional parity and stop-bit checking with registered one-cycle strobes.
module uart_rx #(
    parameter int Width = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [Width-1:0] P_data,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stp_err
);

    localparam int BW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(Width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_next;
    logic [5:0]       edge_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [5:0]       presc_q;
    logic             par_en_q;
    logic             par_typ_q;
    logic [2:0]       samp;
    logic [Width-1:0] shift_q;
    logic             par_flag;

    logic             start_det;
    logic             bit_done;
    logic             maj;
    logic [5:0]       half;
    logic             dv_d;
    logic             pe_d;
    logic             se_d;

    assign start_det = (state == IDLE) && !RX_IN;
    assign bit_done  = (state != IDLE) && (edge_cnt == presc_q - 6'd1);
    assign half      = {1'b0, presc_q[5:1]};
    assign maj       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_det) state_next = START;
            START:   if (bit_done) state_next = maj ? IDLE : DATA;
            DATA:    if (bit_done && bit_cnt == LAST_BIT) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done) state_next = STOP;
            STOP:    if (bit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dv_d = 1'b0;
        pe_d = 1'b0;
        se_d = 1'b0;
        if (state == STOP && bit_done) begin
            se_d = !maj;
            pe_d = par_flag;
            dv_d = maj && !par_flag;
        end
    end

    // The start-detect cycle is edge 0 of the start bit, so counting resumes at 1.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            samp       <= '0;
            shift_q    <= '0;
            par_flag   <= 1'b0;
            P_data     <= '0;
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_valid <= dv_d;
            Par_err    <= pe_d;
            Stp_err    <= se_d;
            if (dv_d) P_data <= shift_q;

            if (state == IDLE) begin
                edge_cnt <= start_det ? 6'd1 : 6'd0;
                if (start_det) begin
                    presc_q   <= Prescale;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    bit_cnt   <= '0;
                    par_flag  <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_done ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) samp[0] <= RX_IN;
                if (edge_cnt == half)        samp[1] <= RX_IN;
                if (edge_cnt == half + 6'd1) samp[2] <= RX_IN;
            end

            if (state == DATA && bit_done) begin
                shift_q <= {maj, shift_q[Width-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == PARITY && bit_done) begin
                par_flag <= (maj != ((^shift_q) ^ par_typ_q));
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frame timing, parity/stop errors,
// glitch rejection, sample noise, back-to-back frames and mid-frame reset.
module tb_uart_rx;

    logic       CLK;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_data;
    logic       Data_valid;
    logic       Par_err;
    logic       Stp_err;

    int passed = 0;
    int total = 0;
    int frame_strobes = 0;
    int idle_strobes = 0;

    uart_rx #(.Width(8)) dut (
        .CLK(CLK),
        .rst(rst),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_data(P_data),
        .Data_valid(Data_valid),
        .Par_err(Par_err),
        .Stp_err(Stp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drives one frame; returns at #1 after edge N*P, i.e. inside the strobe cycle.
    // Strobes seen in cycles 1..N*P-1 are counted into frame_strobes.
    task automatic send(input logic [7:0] d, input logic par_en, input logic par_bit,
                        input logic stop_bit, input int p, input int flip_b,
                        input int flip_j, input int max_cyc);
        logic [11:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (par_en) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            n = 11;
        end else begin
            bits[9] = stop_bit;
            n = 10;
        end
        frame_strobes = 0;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < p; j++) begin
                if (b * p + j >= max_cyc) return;
                RX_IN = (b == flip_b && j == flip_j) ? ~bits[b] : bits[b];
                @(posedge CLK);
                #1;
                if ((b * p + j + 1) != n * p && (Data_valid || Par_err || Stp_err))
                    frame_strobes++;
            end
        end
    endtask

    task automatic check_end(input string tag, input logic dv, input logic pe,
                             input logic se, input logic [7:0] data);
        chk({tag, "_early_strobe"}, frame_strobes, 0);
        chk({tag, "_valid"}, Data_valid, dv);
        chk({tag, "_par_err"}, Par_err, pe);
        chk({tag, "_stp_err"}, Stp_err, se);
        chk({tag, "_data"}, P_data, data);
    endtask

    task automatic check_quiet_next(input string tag);
        @(posedge CLK);
        #1;
        chk({tag, "_pulse_width"}, {Data_valid, Par_err, Stp_err}, 3'b000);
    endtask

    task automatic count_idle(input int cycles);
        idle_strobes = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            if (Data_valid || Par_err || Stp_err) idle_strobes++;
        end
    endtask

    initial begin
        rst = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_data", P_data, 8'h00);
        chk("rst_valid", Data_valid, 1'b0);
        chk("rst_par", Par_err, 1'b0);
        chk("rst_stp", Stp_err, 1'b0);
        rst = 1'b1;
        @(posedge CLK);
        #1;

        // 8N1, P=8: strobe at cycle 80
        Prescale = 6'd8;
        send(8'hA5, 1'b0, 1'b0, 1'b1, 8, -1, -1, 100000);
        RX_IN = 1'b1;
        check_end("8n1", 1'b1, 1'b0, 1'b0, 8'hA5);
        check_quiet_next("8n1");

        // Even parity, P=16: strobe at cycle 176
        Prescale = 6'd16;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        send(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1, -1, 100000);
        RX_IN = 1'b1;
        check_end("even_ok", 1'b1, 1'b0, 1'b0, 8'h3C);
        check_quiet_next("even_ok");
        send(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1, -1, 100000);
        RX_IN = 1'b1;
        check_end("even_bad", 1'b0, 1'b1, 1'b0, 8'h3C);
        check_quiet_next("even_bad");

        // Odd parity (correct bit 0 for 0x01), stop forced 0, P=32: strobe at 352
        Prescale = 6'd32;
        PAR_TYP = 1'b1;
        send(8'h01, 1'b1, 1'b0, 1'b0, 32, -1, -1, 100000);
        RX_IN = 1'b1;
        check_end("stop_err", 1'b0, 1'b0, 1'b1, 8'h3C);
        check_quiet_next("stop_err");

        // Glitch rejection, then a frame with one flipped middle sample in data bit 2
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        count_idle(20);
        chk("glitch_no_strobe", idle_strobes, 0);
        send(8'h96, 1'b0, 1'b0, 1'b1, 8, 3, 4, 100000);
        RX_IN = 1'b1;
        check_end("noise", 1'b1, 1'b0, 1'b0, 8'h96);
        check_quiet_next("noise");

        // Back-to-back at P=16: second start detect lands in the first strobe cycle
        Prescale = 6'd16;
        send(8'h55, 1'b0, 1'b0, 1'b1, 16, -1, -1, 100000);
        check_end("b2b_first", 1'b1, 1'b0, 1'b0, 8'h55);
        send(8'hAA, 1'b0, 1'b0, 1'b1, 16, -1, -1, 100000);
        RX_IN = 1'b1;
        check_end("b2b_second", 1'b1, 1'b0, 1'b0, 8'hAA);
        check_quiet_next("b2b_second");

        // Reset in the middle of bit 4, then a clean frame
        send(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1, -1, 4 * 16 + 8);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {P_data, Data_valid, Par_err, Stp_err}, 11'h000);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        rst = 1'b1;
        count_idle(200);
        chk("midrst_no_strobe", idle_strobes, 0);
        chk("midrst_data_held", P_data, 8'h00);
        send(8'hC3, 1'b0, 1'b0, 1'b1, 16, -1, -1, 100000);
        RX_IN = 1'b1;
        check_end("post_rst", 1'b1, 1'b0, 1'b0, 8'hC3);
        check_quiet_next("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART link: recovers `Width`-bit frames from the serial line `RX_IN` using a programmable oversampling clock ratio, checks optional parity and the stop bit, and presents the data word with a one-cycle valid strobe. It is the receive-side counterpart of the UART transmitter and shares its frame format: start 0, data LSB first, optional parity, stop 1. The line idles high.

## Interface
- `Width`, 8, data bits per frame.
- `CLK`  in  1  oversampling clock; `Prescale` cycles per bit.
- `rst`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already synchronised to `CLK`; idles high.
- `Prescale`  in  6  cycles per bit. Supported values are 8, 16 and 32.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `P_data`  out  `Width`  last good received word.
- `Data_valid`  out  1  one-cycle pulse when a good frame completes.
- `Par_err`  out  1  one-cycle pulse when a parity mismatch occurs.
- `Stp_err`  out  1  one-cycle pulse when the stop bit is sampled 0.

## Operation
- **Reset:** while `rst`=0, all outputs are 0 and the FSM is in IDLE. Reset asserted mid-frame aborts the frame immediately and produces no strobes.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Counters:**
  - `edge_cnt` runs 0..`Prescale`-1 within each bit.
  - `bit_cnt` runs 0..`Width`-1 in DATA.
- **IDLE:**
  - When `RX_IN`=0 on a clock edge, go to START.
  - That cycle counts as `edge_cnt`=0.
  - `Prescale`, `PAR_EN` and `PAR_TYP` are latched in that cycle. Changes mid-frame are ignored.
- **Sampling:**
  - `RX_IN` is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1.
  - The bit value is the majority (2-of-3) of those samples.
  - The bit is resolved at `edge_cnt`=P-1, then `edge_cnt` wraps to 0.
- **START:** resolved bit 1 means a glitch. Return to IDLE with no strobes. Resolved bit 0 means go to DATA.
- **DATA:**
  - Shift in LSB first.
  - After bit `Width`-1, go to PARITY if `PAR_EN`=1, else go to STOP.
- **PARITY:**
  - Expected bit = XOR of the data bits, inverted when `PAR_TYP`=1.
  - A mismatch is recorded and the frame continues to STOP.
- **STOP:** a resolved 0 records a stop error.
- **End of STOP:** the FSM returns to IDLE. In the following cycle exactly one of these happens:
  - No errors: `Data_valid`=1 for one cycle and `P_data` is updated with the shifted word.
  - Any error: `Par_err` and/or `Stp_err` pulse (both may pulse together), `Data_valid` stays 0 and `P_data` is unchanged.
- `P_data` holds its value between good frames. It never shows partial data.

## Timing
- Frame length N = 1 + `Width` + `PAR_EN` + 1 bits.
- Strobes appear in cycle N·P, counting the start-detect cycle as cycle 0. Examples: 10·P for 8N1, 11·P with parity.
- **Back-to-back frames:** the strobe cycle is also an IDLE cycle. If `RX_IN`=0 in that cycle it is the next start detect, so no gap is required between frames.
- Strobes are registered outputs, never combinational from `RX_IN`.
- The strobe-cycle equation above holds for every supported `Prescale`; no other cycle-count rules apply.

## Test plan
- **8N1, P=8:** send 0xA5 -> `Data_valid` high for exactly one cycle at cycle 80, `P_data`=0xA5, no error strobes.
- **Even parity, P=16:** send 0x3C with parity bit 0 -> valid at cycle 176. Then resend 0x3C with parity bit 1 -> `Par_err` pulse only, `P_data` stays 0x3C.
- **Odd parity and stop error, P=32:** send 0x01 with odd parity and stop bit forced 0 -> `Stp_err` pulse at cycle 352, `Data_valid`=0.
- **Glitch and sample noise, P=8:**
  - 3-cycle low glitch on an idle line -> no strobes, FSM back in IDLE.
  - One flipped sample inside the middle sampling window of a data bit -> the word is still received correctly.
- **Back-to-back and reset, P=16:**
  - Frames 0x55 and 0xAA with no idle gap -> two valid pulses 160 cycles apart, with the correct data for each.
  - `rst` low during bit 4 of a frame -> all outputs 0, no strobes.
  - The next clean frame after reset is received correctly.
